control_seq: RTL and testbench

//   Parametrised multi-cycle control sequencer: successor to the single-state fetch controller.

---
 rtl/control_pkg.sv | 75 +++++++
 rtl/wait_timer.sv | 32 +++
 rtl/control_seq.sv | 187 ++++++++++++++++++
 tb/tb_control_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types for the control sequencer: FSM states, opcode/condition encodings,
// the status-flag layout and the condition-code evaluator.
package control_pkg;

    localparam int CTRL_COND_W = 4;
    localparam int CTRL_OP_W   = 4;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM    = 4'd5,
        ST_WB     = 4'd6,
        ST_STOP   = 4'd7,
        ST_IRQ    = 4'd8
    } ctrl_state_e;

    typedef enum logic [CTRL_OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_LOAD  = 4'd8,
        OP_STORE = 4'd9,
        OP_HALT  = 4'd15
    } opcode_e;

    typedef enum logic [CTRL_COND_W-1:0] {
        C_NONE = 4'd0,
        C_EQ   = 4'd1,
        C_NE   = 4'd2,
        C_LTU  = 4'd3,
        C_GTU  = 4'd4,
        C_LEU  = 4'd5,
        C_GEU  = 4'd6,
        C_LTS  = 4'd7,
        C_GTS  = 4'd8,
        C_LES  = 4'd9,
        C_GES  = 4'd10
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } status_t;

    // Codes past C_GES are reserved and evaluate as always-true.
    function automatic logic cond_true(cond_e cond, status_t st);
        logic r;
        case (cond)
            C_NONE:  r = 1'b1;
            C_EQ:    r = st.z;
            C_NE:    r = !st.z;
            C_LTU:   r = !st.c;
            C_GTU:   r = st.c && !st.z;
            C_LEU:   r = !st.c || st.z;
            C_GEU:   r = st.c;
            C_LTS:   r = st.n != st.v;
            C_GTS:   r = !st.z && (st.n == st.v);
            C_LES:   r = st.z || (st.n != st.v);
            C_GES:   r = st.n == st.v;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive memory-wait cycles; expired_o flags the MAX_WAIT-th waiting cycle.
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != LAST)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // cnt_q holds the number of earlier wait cycles, so LAST marks the final allowed one.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/control_seq.sv
// Multi-cycle control sequencer: fetch/decode/exec/memory phases with wait timeout and sticky STOP.
// Optional interrupt entry at fetch is enabled with `define CONTROL_IRQ_EN.
module control_seq
    import control_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int COND_W   = 4,
    parameter int OP_W     = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] ir,
    input  logic [3:0]        status,
    input  logic              mem_rdy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              ld_ir,
    output logic              pc_inc,
    output logic              ld_mar,
    output logic              ld_mdr,
    output logic              ld_reg,
    output logic              ld_status,
    output logic              oe_alu,
    output logic [OP_W-1:0]   alu_op,
    output logic              halted,
    output logic              timeout_err
`ifdef CONTROL_IRQ_EN
    ,
    input  logic              irq,
    output logic              irq_ack,
    output logic              ld_pc_vec
`endif
);

    ctrl_state_e     state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            timeout_q, timeout_d;

    logic [COND_W-1:0] cond_f;
    logic [OP_W-1:0]   op_f;
    logic              cond_ok;
    logic              is_load;
    logic              irq_take;
    logic              in_wait, wt_en, wt_clr, wt_expired;
    logic              unused_ir_bits;

    assign cond_f         = ir[WORD_W-1 -: COND_W];
    assign op_f           = ir[WORD_W-COND_W-1 -: OP_W];
    assign unused_ir_bits = ^ir[WORD_W-COND_W-OP_W-1:0];
    assign cond_ok        = cond_true(cond_e'(cond_f), status_t'(status));
    assign is_load        = (op_q == OP_W'(OP_LOAD));

`ifdef CONTROL_IRQ_EN
    logic first_q, first_d;
    assign irq_take  = (state_q == ST_FETCH) && first_q && irq;
    assign first_d   = (state_d == ST_FETCH) && (state_q != ST_FETCH);
    assign irq_ack   = (state_q == ST_IRQ);
    assign ld_pc_vec = (state_q == ST_IRQ);
`else
    assign irq_take  = 1'b0;
`endif

    // A cycle spent diverting to IRQ is not a memory wait.
    assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wt_en   = ((state_q == ST_FETCH && !irq_take) || state_q == ST_MEM) && !mem_rdy;
    assign wt_clr  = !in_wait || mem_rdy || irq_take;

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wt_clr),
        .en_i      (wt_en),
        .expired_o (wt_expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (irq_take)
                    state_d = ST_IRQ;
                else if (mem_rdy)
                    state_d = ST_DECODE;
                else if (wt_expired) begin
                    state_d   = ST_STOP;
                    timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                op_d = op_f;
                if (!cond_ok)
                    state_d = ST_FETCH;
                else begin
                    case (op_f)
                        OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR),
                        OP_W'(OP_XOR), OP_W'(OP_SHL), OP_W'(OP_SHR):
                            state_d = ST_EXEC;
                        OP_W'(OP_LOAD), OP_W'(OP_STORE):
                            state_d = ST_ADDR;
                        OP_W'(OP_HALT):
                            state_d = ST_STOP;
                        default:
                            state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC: state_d = ST_FETCH;
            ST_ADDR: state_d = ST_MEM;
            ST_MEM: begin
                if (mem_rdy)
                    state_d = is_load ? ST_WB : ST_FETCH;
                else if (wt_expired) begin
                    state_d   = ST_STOP;
                    timeout_d = 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_STOP: state_d = ST_STOP;
            ST_IRQ:  state_d = ST_FETCH;
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            op_q      <= '0;
            timeout_q <= 1'b0;
`ifdef CONTROL_IRQ_EN
            first_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            timeout_q <= timeout_d;
`ifdef CONTROL_IRQ_EN
            first_q   <= first_d;
`endif
        end
    end

    // Strobes follow the state; mem_rdy only qualifies the bus-capture strobes.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        ld_ir     = 1'b0;
        pc_inc    = 1'b0;
        ld_mar    = 1'b0;
        ld_mdr    = 1'b0;
        ld_reg    = 1'b0;
        ld_status = 1'b0;
        oe_alu    = 1'b0;
        alu_op    = '0;
        case (state_q)
            ST_FETCH: begin
                mem_rd = !irq_take;
                ld_ir  = mem_rdy && !irq_take;
                pc_inc = mem_rdy && !irq_take;
            end
            ST_EXEC: begin
                oe_alu    = 1'b1;
                ld_reg    = 1'b1;
                ld_status = 1'b1;
                alu_op    = op_q;
            end
            ST_ADDR: ld_mar = 1'b1;
            ST_MEM: begin
                if (is_load) begin
                    mem_rd = 1'b1;
                    ld_mdr = mem_rdy;
                end else begin
                    mem_wr = 1'b1;
                end
            end
            ST_WB:   ld_reg = 1'b1;
            default: ;
        endcase
    end

    assign halted      = (state_q == ST_STOP);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: a per-cycle vector table plus hand sequences for
// wait-timeout boundaries, HALT, mid-instruction reset and (when enabled) interrupt entry.
module tb_control_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ir = '0;
    logic [3:0]  status = '0;
    logic        mem_rdy = 1'b0;
    logic        mem_rd, mem_wr, ld_ir, pc_inc, ld_mar, ld_mdr, ld_reg, ld_status, oe_alu;
    logic [3:0]  alu_op;
    logic        halted, timeout_err;
`ifdef CONTROL_IRQ_EN
    logic        irq = 1'b0;
    logic        irq_ack, ld_pc_vec;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_seq #(.WORD_W(32), .COND_W(4), .OP_W(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .status(status), .mem_rdy(mem_rdy),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ld_ir(ld_ir), .pc_inc(pc_inc),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_reg(ld_reg), .ld_status(ld_status),
        .oe_alu(oe_alu), .alu_op(alu_op), .halted(halted), .timeout_err(timeout_err)
`ifdef CONTROL_IRQ_EN
        , .irq(irq), .irq_ack(irq_ack), .ld_pc_vec(ld_pc_vec)
`endif
    );

    logic [14:0] obs;
    assign obs = {mem_rd, mem_wr, ld_ir, pc_inc, ld_mar, ld_mdr, ld_reg, ld_status,
                  oe_alu, alu_op, halted, timeout_err};

    localparam logic [14:0] NONE_O = 15'h0000;
    localparam logic [14:0] RD  = 15'h4000;
    localparam logic [14:0] WR  = 15'h2000;
    localparam logic [14:0] LIR = 15'h1000;
    localparam logic [14:0] PCI = 15'h0800;
    localparam logic [14:0] MAR = 15'h0400;
    localparam logic [14:0] MDR = 15'h0200;
    localparam logic [14:0] REG = 15'h0100;
    localparam logic [14:0] STS = 15'h0080;
    localparam logic [14:0] ALU = 15'h0040;
    localparam logic [14:0] HLT = 15'h0002;
    localparam logic [14:0] TOE = 15'h0001;
    localparam logic [14:0] FET = RD | LIR | PCI;

    localparam logic [3:0] CN   = 4'd0;
    localparam logic [3:0] CEQ  = 4'd1;
    localparam logic [3:0] CNE  = 4'd2;
    localparam logic [3:0] CGTU = 4'd4;
    localparam logic [3:0] CLTS = 4'd7;
    localparam logic [3:0] CGTS = 4'd8;

    function automatic logic [14:0] opv(input logic [3:0] o);
        return {9'b0, o, 2'b0};
    endfunction

    function automatic logic [14:0] exe(input logic [3:0] o);
        return ALU | REG | STS | opv(o);
    endfunction

    function automatic logic [31:0] ins(input logic [3:0] c, input logic [3:0] o);
        return {c, o, 24'h5a5a5a};
    endfunction

    typedef struct {
        logic        rdy;
        logic [31:0] ir;
        logic [3:0]  st;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [31:0] i, input logic [3:0] s, input logic [14:0] e);
        vec_t v;
        v.rdy = r; v.ir = i; v.st = s; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check the outputs, then advance past the next edge.
    task automatic cyc(input logic r, input logic [31:0] i, input logic [3:0] s,
                       input logic [14:0] e, input string nm);
        mem_rdy = r; ir = i; status = s;
        #1;
        chk(nm, obs, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_rdy = 1'b0;
        #1;
        chk("reset_async", obs, NONE_O);
        @(posedge clk);
        #1;
        chk("reset_hold", obs, NONE_O);
        rst_n = 1'b1;
    endtask

    initial begin
        // Main program: one row per clock, starting in RESET.
        add(0, '0, 4'h0, NONE_O);                 // RESET
        add(1, '0, 4'h0, FET);                    // fetch ALU op 3
        add(0, ins(CN, 4'd3), 4'h0, NONE_O);      // decode
        add(0, ins(CN, 4'd9), 4'h0, exe(4'd3));   // exec, ir change ignored
        add(0, '0, 4'h0, RD);                     // fetch waits one cycle
        add(1, '0, 4'h0, FET);
        add(0, ins(CEQ, 4'd3), 4'b0000, NONE_O);  // EQ false -> skip
        add(1, '0, 4'h0, FET);
        add(0, ins(CEQ, 4'd3), 4'b0100, NONE_O);  // EQ true
        add(0, '0, 4'b0000, exe(4'd3));
        add(1, '0, 4'h0, FET);
        add(0, ins(CN, 4'd8), 4'h0, NONE_O);      // LOAD
        add(0, '0, 4'h0, MAR);
        add(0, '0, 4'h0, RD);
        add(0, '0, 4'h0, RD);
        add(0, '0, 4'h0, RD);
        add(1, '0, 4'h0, RD | MDR);
        add(0, '0, 4'h0, REG);                    // WB
        add(1, '0, 4'h0, FET);
        add(0, ins(CN, 4'd9), 4'h0, NONE_O);      // STORE
        add(0, '0, 4'h0, MAR);
        add(0, '0, 4'h0, WR);
        add(1, '0, 4'h0, WR);
        add(1, '0, 4'h0, FET);
        add(0, ins(CGTS, 4'd5), 4'b1001, NONE_O); // GTS true (n==v, !z)
        add(0, '0, 4'h0, exe(4'd5));
        add(1, '0, 4'h0, FET);
        add(0, ins(CLTS, 4'd2), 4'b1001, NONE_O); // LTS false
        add(1, '0, 4'h0, FET);
        add(0, ins(CN, 4'd12), 4'h0, NONE_O);     // undefined opcode = NOP
        add(1, '0, 4'h0, FET);
        add(0, ins(CGTU, 4'd7), 4'b0010, NONE_O); // GTU true
        add(0, '0, 4'h0, exe(4'd7));
        add(1, '0, 4'h0, FET);
        add(0, ins(CNE, 4'd1), 4'b0100, NONE_O);  // NE false
        add(1, '0, 4'h0, FET);
        add(0, ins(4'd13, 4'd1), 4'h0, NONE_O);   // reserved cond = true
        add(0, '0, 4'h0, exe(4'd1));
        add(0, '0, 4'h0, RD);                     // fetch wait cycle 1

        #2;
        do_reset();
        foreach (tbl[k]) cyc(tbl[k].rdy, tbl[k].ir, tbl[k].st, tbl[k].exp, $sformatf("vec%0d", k));

        // Wait cycles 2..14, then mem_rdy on the 15th: completes, no trap.
        for (int k = 2; k <= 14; k++) cyc(0, '0, 4'h0, RD, $sformatf("fetch_wait%0d", k));
        cyc(1, '0, 4'h0, FET, "rdy_at_max_wait");
        cyc(0, ins(CN, 4'd0), 4'h0, NONE_O, "decode_after_max_wait");

        // Fetch timeout: 15 wait cycles then STOP with timeout_err.
        for (int k = 1; k <= 15; k++) cyc(0, '0, 4'h0, RD, $sformatf("to_wait%0d", k));
        for (int k = 0; k < 20; k++)
            cyc(k[0], $urandom, 4'($urandom), HLT | TOE, $sformatf("to_stop%0d", k));

        // Reset clears timeout_err; then a MEM-phase timeout.
        do_reset();
        cyc(0, '0, 4'h0, NONE_O, "reset_state");
        cyc(1, '0, 4'h0, FET, "mem_to_fetch");
        cyc(0, ins(CN, 4'd8), 4'h0, NONE_O, "mem_to_decode");
        cyc(0, '0, 4'h0, MAR, "mem_to_addr");
        for (int k = 1; k <= 15; k++) cyc(0, '0, 4'h0, RD, $sformatf("mem_wait%0d", k));
        cyc(1, '0, 4'h0, HLT | TOE, "mem_to_stop");

        // HALT opcode: sticky STOP with no timeout flag.
        do_reset();
        cyc(0, '0, 4'h0, NONE_O, "halt_reset");
        cyc(1, '0, 4'h0, FET, "halt_fetch");
        cyc(0, ins(CN, 4'd15), 4'h0, NONE_O, "halt_decode");
        for (int k = 0; k < 100; k++)
            cyc(1'($urandom), $urandom, 4'($urandom), HLT, $sformatf("halt%0d", k));

        // Reset asserted in the middle of EXEC.
        do_reset();
        cyc(0, '0, 4'h0, NONE_O, "rx_reset");
        cyc(1, '0, 4'h0, FET, "rx_fetch");
        cyc(0, ins(CN, 4'd6), 4'h0, NONE_O, "rx_decode");
        #1;
        chk("rx_exec", obs, exe(4'd6));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rx_abort_now", obs, NONE_O);
        @(posedge clk);
        #1;
        chk("rx_abort_hold", obs, NONE_O);
        rst_n = 1'b1;
        cyc(0, '0, 4'h0, NONE_O, "rx_restart_reset");
        cyc(1, '0, 4'h0, FET, "rx_restart_fetch");

`ifdef CONTROL_IRQ_EN
        do_reset();
        cyc(0, '0, 4'h0, NONE_O, "irq_reset");
        irq = 1'b1;
        mem_rdy = 1'b1;
        #1;
        chk("irq_fetch_first", obs, NONE_O);
        chk("irq_fetch_ack", {13'b0, irq_ack, ld_pc_vec}, 15'h0);
        @(posedge clk);
        #1;
        irq = 1'b0;
        mem_rdy = 1'b0;
        #1;
        chk("irq_state", obs, NONE_O);
        chk("irq_ack", {13'b0, irq_ack, ld_pc_vec}, 15'h3);
        @(posedge clk);
        #1;
        cyc(1, '0, 4'h0, FET, "irq_then_fetch");
        cyc(0, ins(CN, 4'd0), 4'h0, NONE_O, "irq_nop_decode");
        cyc(0, '0, 4'h0, RD, "irq_fetch_wait");
        irq = 1'b1;
        mem_rdy = 1'b0;
        #1;
        chk("irq_late_ignored", obs, RD);
        chk("irq_late_noack", {13'b0, irq_ack, ld_pc_vec}, 15'h0);
        @(posedge clk);
        #1;
        irq = 1'b0;
        cyc(1, '0, 4'h0, FET, "irq_late_fetch");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
